pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage ARMv8 pipeline. It drives the enable and synchronous-clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes: data-memory wait, taken branch resolved in MEM, and load-use. It keeps saturating performance counters and a sticky memory-timeout flag.

## Interface

Parameters:
- CNT_W, 16, width of stall_cycles and flush_events
- TIMEOUT, 64, maximum consecutive memory-wait cycles before timeout_err

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source
- ex_memread  in  1  instruction in EX is a load (LDUR)
- ex_rd  in  5  destination register of the instruction in EX
- mem_branch_taken  in  1  branch in MEM resolved taken
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- pc_sel_branch  out  1  PC loads the branch target instead of PC+4
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear (bubble insert)
- stall_cycles  out  CNT_W  count of cycles with pc_en=0
- flush_events  out  CNT_W  count of taken-branch flushes
- timeout_err  out  1  sticky; set when the wait counter reaches TIMEOUT

## Operation

- FSM states: RUN, MWAIT.
- Control outputs are combinational from the current state and the inputs. Counters, wait counter and timeout_err are registered.
- Priority, highest first: Reset > memory wait > branch flush > load-use > normal.
- Memory wait applies when mem_req=1 and mem_ready=0, in either state:
  - all five enables = 0, all flushes = 0;
  - the next state is MWAIT;
  - the wait counter increments, saturating at TIMEOUT;
  - timeout_err is set when the counter reaches TIMEOUT.
- MWAIT with mem_ready=1: this is the release cycle. Enables = 1, the next state is RUN and the wait counter clears. Branch and load-use are evaluated normally in the same cycle.
- Branch flush applies when mem_branch_taken=1 and there is no wait:
  - pc_en=1, pc_sel_branch=1;
  - all enables = 1;
  - ifid_flush=1, idex_flush=1, exmem_flush=1;
  - flush_events increments;
  - load-use is ignored, because the ID instruction is squashed.
- Load-use applies when ex_memread=1, ex_rd≠31 (XZR), and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd):
  - pc_en=0, ifid_en=0, idex_flush=1;
  - exmem_en=1, memwb_en=1.
  
  This inserts exactly one bubble. In the next cycle the load is in MEM, so the hazard clears without any extra state.
- Normal cycle: all enables = 1, all flushes = 0, pc_sel_branch=0.
- stall_cycles increments on every non-Reset cycle with pc_en=0, covering both memory wait and load-use.
- Both counters saturate at all-ones.

## Timing

- Reset (synchronous):
  - state RUN, wait counter 0;
  - stall_cycles=0, flush_events=0, timeout_err=0;
  - while Reset=1: all enables 0; ifid_flush, idex_flush and exmem_flush = 1; pc_sel_branch=0.
- Reset asserted during MWAIT: the FSM returns to RUN on the next edge and no release cycle is produced.
- Control latency is 0 cycles, because outputs respond in the same cycle as their inputs. Counter updates are visible 1 cycle later.
- Load-use: exactly 1 stall cycle per hazard. Back-to-back dependent loads each stall once.
- Branch: 1 cycle of flush. The three younger instructions are discarded and the target is fetched on the next edge.
- Memory wait of N cycles:
  - N cycles with pc_en=0, then 1 release cycle;
  - stall_cycles increases by N;
  - timeout_err rises on the edge where the wait count reaches TIMEOUT and stays set until Reset.
- mem_branch_taken and mem_req are never both 1, because they come from the same MEM instruction. If both are asserted, memory wait wins.

## Structure

- Shared package pipe_ctrl_pkg holds:
  - the state typedef {RUN, MWAIT};
  - the constant XZR = 5'd31;
  - the bundle of enable/flush signal names used by the top-level datapath.
- One sub-module, sat_counter (parameter W; inputs clk, Reset, inc; output count), saturating at all-ones. It is instantiated twice, for stall_cycles and flush_events.
- Load-use comparison and the FSM stay inline.

## Test plan

- Reset held for 2 cycles with mem_req=1:
  - during Reset: all enables 0, three flushes 1;
  - after release: all counters 0, timeout_err=0.
- Load-use, ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1:
  - 1 cycle with pc_en=0, ifid_en=0, idex_flush=1;
  - next cycle is normal;
  - stall_cycles=1.
  - Repeat with ex_rd=31: no stall.
- mem_branch_taken pulse with a simultaneous load-use match:
  - pc_sel_branch=1 and three flushes for 1 cycle, with no stall;
  - flush_events=1.
- mem_req=1 with mem_ready low for 3 cycles, then high:
  - 3 cycles of all enables 0, then 1 release cycle with enables 1;
  - stall_cycles=3;
  - the FSM returns to RUN.
- TIMEOUT=4 with mem_ready held low for 6 cycles:
  - timeout_err=1 after the 4th wait cycle and it stays 1;
  - Reset asserted mid-wait returns to RUN and clears timeout_err.
- CNT_W=4 with 20 load-use stalls: stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states,
// the zero-register index and the enable/flush control bundle.
package pipe_ctrl_pkg;

  typedef enum logic {RUN, MWAIT} state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic pc_sel_branch;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORM = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                  exmem_en: 1'b1, memwb_en: 1'b1,
                                  pc_sel_branch: 1'b0, ifid_flush: 1'b0,
                                  idex_flush: 1'b0, exmem_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: memory wait, taken
// branch in MEM and load-use, plus perf counters and a sticky timeout flag.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             pc_sel_branch,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_MAX = WW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q;
  ctrl_t         ctrl;
  logic          mem_wait, load_use, stall_inc, flush_inc;

  assign mem_wait = mem_req && !mem_ready;
  assign load_use = ex_memread && (ex_rd != XZR) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    ctrl      = CTRL_NORM;
    state_d   = state_q;
    wait_d    = wait_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (Reset) begin
      ctrl             = '0;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      state_d          = RUN;
      wait_d           = '0;
    end else if (mem_wait) begin
      ctrl      = '0;
      state_d   = MWAIT;
      // A fresh wait starts at 1; an ongoing one saturates at TIMEOUT.
      if (state_q == RUN)       wait_d = WW'(1);
      else if (wait_q != TO_MAX) wait_d = wait_q + 1'b1;
      stall_inc = 1'b1;
    end else begin
      state_d = RUN;
      wait_d  = '0;
      if (mem_branch_taken) begin
        ctrl.pc_sel_branch = 1'b1;
        ctrl.ifid_flush    = 1'b1;
        ctrl.idex_flush    = 1'b1;
        ctrl.exmem_flush   = 1'b1;
        flush_inc          = 1'b1;
      end else if (load_use) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
        stall_inc       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (mem_wait && (wait_d == TO_MAX)) timeout_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .Reset(Reset), .inc(stall_inc), .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .Reset(Reset), .inc(flush_inc), .count(flush_events)
  );

  assign pc_en         = ctrl.pc_en;
  assign ifid_en       = ctrl.ifid_en;
  assign idex_en       = ctrl.idex_en;
  assign exmem_en      = ctrl.exmem_en;
  assign memwb_en      = ctrl.memwb_en;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign ifid_flush    = ctrl.ifid_flush;
  assign idex_flush    = ctrl.idex_flush;
  assign exmem_flush   = ctrl.exmem_flush;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4, TIMEOUT=4): expected control
// words are queued when each step is driven and checked mid-cycle.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // {pc,ifid,idex,exmem,memwb enables, pc_sel_branch, ifid,idex,exmem flush}
  localparam logic [8:0] C_NORM = 9'b11111_0_000;
  localparam logic [8:0] C_WAIT = 9'b00000_0_000;
  localparam logic [8:0] C_RST  = 9'b00000_0_111;
  localparam logic [8:0] C_BR   = 9'b11111_1_111;
  localparam logic [8:0] C_LU   = 9'b00111_0_010;

  typedef struct {
    string      tag;
    logic [8:0] ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic mem_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_sel_branch;
  logic ifid_flush, idex_flush, exmem_flush, timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk(clk), .Reset(Reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .pc_sel_branch(pc_sel_branch),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .timeout_err(timeout_err)
  );

  wire [8:0] ctrl_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_sel_branch,
                         ifid_flush, idex_flush, exmem_flush};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs already set; queue the expectation, check mid-cycle, cross the edge.
  task automatic step(input string tag, input logic [8:0] exp);
    exp_t e;
    sb.push_back('{tag: tag, ctrl: exp});
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, 16'(ctrl_obs), 16'(e.ctrl));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_memread = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    mem_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    // Reset for 2 cycles with a pending memory request
    Reset = 1; mem_req = 1;
    step("rst0", C_RST);
    step("rst1", C_RST);
    Reset = 0; idle();
    chk("rst_stall", 16'(stall_cycles), 16'd0);
    chk("rst_flush", 16'(flush_events), 16'd0);
    chk("rst_to", 16'(timeout_err), 16'd0);
    step("norm0", C_NORM);

    // Load-use on rs2
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    step("lu_rs2", C_LU);
    idle();
    step("lu_after", C_NORM);
    chk("lu_stall", 16'(stall_cycles), 16'd1);

    // Destination XZR never hazards
    ex_memread = 1; ex_rd = 31; id_rs2 = 31; id_use_rs2 = 1;
    step("lu_xzr", C_NORM);
    chk("xzr_stall", 16'(stall_cycles), 16'd1);

    // rs1 match only counts when rs1 is actually read
    ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; id_use_rs2 = 0;
    step("lu_rs1", C_LU);
    id_use_rs1 = 0;
    step("lu_rs1_unused", C_NORM);
    ex_memread = 0; id_use_rs1 = 1;
    step("lu_not_load", C_NORM);
    idle();
    chk("rs1_stall", 16'(stall_cycles), 16'd2);

    // Branch beats a simultaneous load-use
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; mem_branch_taken = 1;
    step("br_lu", C_BR);
    idle();
    step("br_after", C_NORM);
    chk("br_flush", 16'(flush_events), 16'd1);
    chk("br_stall", 16'(stall_cycles), 16'd2);

    // 3-cycle memory wait then release
    mem_req = 1; mem_ready = 0;
    step("mw0", C_WAIT);
    step("mw1", C_WAIT);
    step("mw2", C_WAIT);
    mem_ready = 1;
    step("mw_rel", C_NORM);
    idle();
    step("mw_after", C_NORM);
    chk("mw_stall", 16'(stall_cycles), 16'd5);
    chk("mw_to", 16'(timeout_err), 16'd0);

    // Wait wins over branch; branch honoured in the release cycle
    mem_req = 1; mem_ready = 0; mem_branch_taken = 1;
    step("mw_br", C_WAIT);
    mem_ready = 1;
    step("rel_br", C_BR);
    idle();
    chk("relbr_stall", 16'(stall_cycles), 16'd6);
    chk("relbr_flush", 16'(flush_events), 16'd2);

    // Timeout: 6 wait cycles, flag rises after the 4th and sticks
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("to_wait%0d", i), C_WAIT);
      chk($sformatf("to_flag%0d", i), 16'(timeout_err), (i >= 4) ? 16'd1 : 16'd0);
    end
    chk("to_stall", 16'(stall_cycles), 16'd12);

    // Reset mid-wait clears everything
    Reset = 1;
    step("to_rst", C_RST);
    Reset = 0;
    chk("to_rst_flag", 16'(timeout_err), 16'd0);
    chk("to_rst_stall", 16'(stall_cycles), 16'd0);
    mem_ready = 1;
    step("post_rst", C_NORM);
    mem_ready = 0;
    step("new_wait", C_WAIT);
    chk("new_wait_to", 16'(timeout_err), 16'd0);
    idle();
    step("norm1", C_NORM);

    // 20 back-to-back load-use stalls saturate a 4-bit counter
    ex_memread = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    for (int i = 0; i < 20; i++) step($sformatf("sat_lu%0d", i), C_LU);
    idle();
    chk("sat_stall", 16'(stall_cycles), 16'd15);
    chk("sat_flush", 16'(flush_events), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
